// File: rtl/rotary_value_ctl_if.sv
// Bundle between the encoder/button front-ends and the value controller.
// master drives events and buttons, slave returns values and display focus.
interface rotary_value_ctl_if #(
    parameter int WIDTH = 8
);
    logic             rot0_cw;
    logic             rot0_ccw;
    logic             rot1_cw;
    logic             rot1_ccw;
    logic [15:0]      buttons;
    logic [WIDTH-1:0] value0;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] disp_value;
    logic             disp_sel;
    logic             coarse;
    logic [1:0]       changed;

    modport master (
        output rot0_cw, rot0_ccw, rot1_cw, rot1_ccw, buttons,
        input  value0, value1, disp_value, disp_sel, coarse, changed
    );

    modport slave (
        input  rot0_cw, rot0_ccw, rot1_cw, rot1_ccw, buttons,
        output value0, value1, disp_value, disp_sel, coarse, changed
    );
endinterface

// File: rtl/rotary_value_ctl.sv
// Two encoder-stepped values with button clear/coarse control and a
// focus display scheduler that auto-alternates between them when idle.
module rotary_value_ctl #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000,
    parameter int          WRAP        = 1,
    parameter int          COARSE_STEP = 16
) (
    input logic               clk,
    input logic               reset,
    rotary_value_ctl_if.slave bus
);
    typedef enum logic {FOCUS = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [31:0] HOLD_LAST = HOLD_CYCLES - 32'd1;

    logic [WIDTH-1:0] value0_q, value0_d;
    logic [WIDTH-1:0] value1_q, value1_d;
    logic [2:0]       btn_q, btn_d;
    logic             coarse_q, coarse_d;
    logic [1:0]       changed_q, changed_d;
    logic             disp_sel_q, disp_sel_d;
    logic [31:0]      timer_q, timer_d;
    state_t           state_q, state_d;

    logic [2:0]       btn_edge;
    logic [WIDTH:0]   step;
    logic             ev0;
    logic             ev1;
    logic             unused_btn;

    assign unused_btn = ^bus.buttons[15:3];

    function automatic logic [WIDTH-1:0] next_val(
        input logic [WIDTH-1:0] v,
        input logic             clr,
        input logic             up,
        input logic             dn,
        input logic [WIDTH:0]   stp
    );
        logic [WIDTH:0] sum;
        logic [WIDTH:0] dif;
        sum = {1'b0, v} + stp;
        dif = {1'b0, v} - stp;
        next_val = v;
        if (clr) begin
            next_val = '0;
        end else if (up && !dn) begin
            if (WRAP == 0 && sum[WIDTH]) next_val = '1;
            else                         next_val = sum[WIDTH-1:0];
        end else if (dn && !up) begin
            if (WRAP == 0 && dif[WIDTH]) next_val = '0;
            else                         next_val = dif[WIDTH-1:0];
        end
    endfunction

    // Button edges, value stepping and change detection
    always_comb begin
        btn_d    = bus.buttons[2:0];
        btn_edge = bus.buttons[2:0] & ~btn_q;
        step     = coarse_q ? (WIDTH+1)'(COARSE_STEP) : (WIDTH+1)'(1);
        coarse_d = coarse_q ^ btn_edge[2];
        value0_d = next_val(value0_q, btn_edge[0], bus.rot0_cw,
                            bus.rot0_ccw, step);
        value1_d = next_val(value1_q, btn_edge[1], bus.rot1_cw,
                            bus.rot1_ccw, step);
        changed_d = {value1_d != value1_q, value0_d != value0_q};
        ev0 = btn_edge[0] | (bus.rot0_cw ^ bus.rot0_ccw);
        ev1 = btn_edge[1] | (bus.rot1_cw ^ bus.rot1_ccw);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value0_q  <= '0;
            value1_q  <= '0;
            btn_q     <= '0;
            coarse_q  <= 1'b0;
            changed_q <= 2'b00;
        end else begin
            value0_q  <= value0_d;
            value1_q  <= value1_d;
            btn_q     <= btn_d;
            coarse_q  <= coarse_d;
            changed_q <= changed_d;
        end
    end

    // Scheduler state, timer and focus select registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FOCUS;
            timer_q    <= '0;
            disp_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            disp_sel_q <= disp_sel_d;
        end
    end

    // Scheduler next state: events pin focus, idle hold enters scan
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FOCUS: if (!(ev0 || ev1) && timer_q == HOLD_LAST) state_d = SCAN;
            SCAN:  if (ev0 || ev1) state_d = FOCUS;
            default: state_d = FOCUS;
        endcase
    end

    // Scheduler outputs: focus selection and hold timer
    always_comb begin
        disp_sel_d = disp_sel_q;
        timer_d    = timer_q + 32'd1;
        if (ev0 || ev1) begin
            disp_sel_d = ev0 ? 1'b0 : 1'b1;
            timer_d    = '0;
        end else if (timer_q == HOLD_LAST) begin
            timer_d = '0;
            if (state_q == SCAN) disp_sel_d = ~disp_sel_q;
        end
    end

    assign bus.value0     = value0_q;
    assign bus.value1     = value1_q;
    assign bus.disp_sel   = disp_sel_q;
    assign bus.disp_value = disp_sel_q ? value1_q : value0_q;
    assign bus.coarse     = coarse_q;
    assign bus.changed    = changed_q;
endmodule
